simd_booth_engine: RTL

SIMD_BOOTH_ENGINE -- requirements
Module: simd_booth_engine

---
 rtl/simd_booth_engine.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/simd_booth_engine.sv
// SIMD radix-2 Booth multiplier: one lane of W, two lanes of W/2 or four
// lanes of W/4 bits, signed or unsigned, one Booth step per clock on all lanes.
module simd_booth_engine #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     mode,
  input  logic           signed_en,
  input  logic [W-1:0]   M,
  input  logic [W-1:0]   Q,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] result,
  output logic           err
);

  // Each lane slot is sized for the widest lane: the accumulator has two
  // guard bits (zero-extension for unsigned plus headroom for -2^(N-1)
  // subtraction) and the multiplier register has one extension bit.
  localparam int AW    = W + 2;
  localparam int QW    = W + 1;
  localparam int CW    = $clog2(W + 2);
  localparam int LANES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             valid_q;
  logic             err_q;
  logic             alive_q;
  logic [2*W-1:0]   result_q;
  logic [1:0]       mode_q;
  logic             sgn_q;

  logic [AW-1:0]    acc_q   [LANES];
  logic [AW-1:0]    acc_d   [LANES];
  logic [AW-1:0]    mc_q    [LANES];
  logic [AW-1:0]    mc_d    [LANES];
  logic [QW-1:0]    mq_q    [LANES];
  logic [QW-1:0]    mq_d    [LANES];
  logic             qm1_q   [LANES];
  logic             qm1_d   [LANES];
  logic [AW-1:0]    accStep [LANES];
  logic [QW-1:0]    mqStep  [LANES];
  logic             qm1Step [LANES];

  logic             accept;
  logic [CW-1:0]    stepsNew;
  logic [2*W-1:0]   resultRun;
  int               startWidth;
  int               runWidth;
  int               shamt;

  function automatic int laneWidth(input logic [1:0] m);
    case (m)
      2'b01:   return W / 2;
      2'b10:   return W / 4;
      default: return W;
    endcase
  endfunction

  // Lane operand (already shifted down to bit 0) extended from n bits to AW.
  function automatic logic [AW-1:0] extendLane(input logic [W-1:0] v, input int n,
                                               input logic s);
    logic [AW-1:0] vp;
    logic [AW-1:0] low;
    logic          sb;
    vp  = {2'b00, v};
    sb  = s & (|(vp & (AW'(1) << (n - 1))));
    low = ~({AW{1'b1}} << n);
    return (vp & low) | ({AW{sb}} & ~low);
  endfunction

  // Multiplier placed in the top n+1 bits so shifted-in product bits always
  // enter at bit W and {acc, mq} forms one contiguous product.
  function automatic logic [QW-1:0] loadMultiplier(input logic [W-1:0] v, input int n,
                                                   input logic s);
    logic [AW-1:0] x;
    x = extendLane(v, n, s) & ~({AW{1'b1}} << (n + 1));
    x = x << (W - n);
    return QW'(x);
  endfunction

  function automatic void boothStep(input  logic [AW-1:0] acc,
                                    input  logic [QW-1:0] mq,
                                    input  logic          qm1,
                                    input  logic [AW-1:0] mc,
                                    input  int            base,
                                    output logic [AW-1:0] accN,
                                    output logic [QW-1:0] mqN,
                                    output logic          qm1N);
    logic          qLsb;
    logic [AW-1:0] sum;
    qLsb = |(mq & (QW'(1) << base));
    case ({qLsb, qm1})
      2'b10:   sum = acc - mc;
      2'b01:   sum = acc + mc;
      default: sum = acc;
    endcase
    accN = {sum[AW-1], sum[AW-1:1]};
    mqN  = {sum[0], mq[QW-1:1]};
    qm1N = qLsb;
  endfunction

  function automatic logic [2*W-1:0] laneProduct(input logic [AW-1:0] acc,
                                                 input logic [QW-1:0] mq,
                                                 input int sh);
    return (2*W)'({acc, mq} >> sh);
  endfunction

  function automatic logic [2*W-1:0] laneMask(input int n);
    return ~({(2*W){1'b1}} << (2 * n));
  endfunction

  assign in_ready  = alive_q & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = valid_q;
  assign result    = result_q;
  assign err       = err_q;

  // Lane datapath: load on accept, one Booth step per RUN cycle, and the
  // packed product as it will look after the current step.
  always_comb begin
    startWidth = laneWidth(mode);
    runWidth   = laneWidth(mode_q);
    shamt      = sgn_q ? (W + 1 - runWidth) : (W - runWidth);
    if (mode == 2'b11) begin
      stepsNew = CW'(1);
    end else if (signed_en) begin
      stepsNew = CW'(startWidth);
    end else begin
      stepsNew = CW'(startWidth + 1);
    end
    resultRun = '0;
    for (int i = 0; i < LANES; i++) begin
      boothStep(acc_q[i], mq_q[i], qm1_q[i], mc_q[i], W - runWidth,
                accStep[i], mqStep[i], qm1Step[i]);
      resultRun = resultRun |
                  ((laneProduct(accStep[i], mqStep[i], shamt) & laneMask(runWidth))
                   << (2 * runWidth * i));
      acc_d[i] = acc_q[i];
      mc_d[i]  = mc_q[i];
      mq_d[i]  = mq_q[i];
      qm1_d[i] = qm1_q[i];
      if (accept) begin
        acc_d[i] = '0;
        mc_d[i]  = extendLane(M >> (startWidth * i), startWidth, signed_en);
        mq_d[i]  = loadMultiplier(Q >> (startWidth * i), startWidth, signed_en);
        qm1_d[i] = 1'b0;
      end else if (state_q == RUN) begin
        acc_d[i] = accStep[i];
        mq_d[i]  = mqStep[i];
        qm1_d[i] = qm1Step[i];
      end
    end
  end

  // Lane state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) begin
        acc_q[i] <= '0;
        mc_q[i]  <= '0;
        mq_q[i]  <= '0;
        qm1_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        acc_q[i] <= acc_d[i];
        mc_q[i]  <= mc_d[i];
        mq_q[i]  <= mq_d[i];
        qm1_q[i] <= qm1_d[i];
      end
    end
  end

  // Control FSM with registered result, err and out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      alive_q  <= 1'b0;
      result_q <= '0;
      mode_q   <= 2'b00;
      sgn_q    <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            mode_q  <= mode;
            sgn_q   <= signed_en;
            cnt_q   <= stepsNew;
            valid_q <= 1'b0;
            state_q <= RUN;
            if (mode != 2'b11) begin
              err_q <= 1'b0;
            end
          end else if ((state_q == DONE) && out_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q <= CW'(1)) begin
            state_q <= DONE;
            valid_q <= 1'b1;
            if (mode_q == 2'b11) begin
              result_q <= '0;
              err_q    <= 1'b1;
            end else begin
              result_q <= resultRun;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
